// File: rtl/traffic_phase_ctrl.sv
// Single-approach traffic light phase sequencer driving an external cycle timer.
// Optional watchdog (FLASH state, fault output) is built when WATCHDOG_EN is defined.
module traffic_phase_ctrl #(
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 4,
  parameter int T_WALK   = 3
`ifdef WATCHDOG_EN
  , parameter int WDT_LIMIT = 31
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       timer_done,
  input  logic       ped_req,
  output logic [2:0] timer_max,
  output logic       timer_restart,
  output logic [2:0] light,
  output logic       walk,
  output logic       ped_ack,
  output logic       fault
);

  typedef enum logic [2:0] {S_GREEN, S_YELLOW, S_RED, S_WALK, S_FLASH} state_t;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  function automatic logic [2:0] phase_max(input state_t s);
    case (s)
      S_GREEN:  phase_max = 3'(T_GREEN);
      S_YELLOW: phase_max = 3'(T_YELLOW);
      S_WALK:   phase_max = 3'(T_WALK);
      default:  phase_max = 3'(T_RED);
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [1:0] blank_q, blank_d;
  logic       pending_q, pending_d;
  logic [2:0] timer_max_q, timer_max_d;
  logic       timer_restart_q, timer_restart_d;
  logic [2:0] light_q, light_d;
  logic       walk_q, walk_d;
  logic       ped_ack_q, ped_ack_d;
  logic       accept, wdt_trip, phase_entry;

`ifdef WATCHDOG_EN
  logic [4:0] wdt_q, wdt_d;
  logic       fault_q, fault_d;
`endif

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d         = state_q;
    blank_d         = (blank_q != 2'd0) ? blank_q - 2'd1 : 2'd0;
    pending_d       = pending_q | ped_req;
    timer_max_d     = timer_max_q;
    timer_restart_d = 1'b0;
    ped_ack_d       = 1'b0;
    phase_entry     = 1'b0;
    wdt_trip        = 1'b0;
    // A stale done flag from the previous phase is masked while blank is non-zero.
    accept          = (blank_q == 2'd0) && timer_done;

`ifdef WATCHDOG_EN
    wdt_d    = (state_q == S_FLASH) ? wdt_q : wdt_q + 5'd1;
    wdt_trip = (state_q != S_FLASH) && (wdt_q == 5'(WDT_LIMIT - 1));
`endif

    if (state_q == S_FLASH) begin
      pending_d = pending_q;
    end else if (wdt_trip) begin
      state_d = S_FLASH;
    end else if (accept) begin
      phase_entry = 1'b1;
      case (state_q)
        S_GREEN:  state_d = S_YELLOW;
        S_YELLOW: state_d = S_RED;
        S_RED:    state_d = pending_q ? S_WALK : S_GREEN;
        default:  state_d = S_GREEN;
      endcase
    end

    if (phase_entry) begin
      blank_d         = 2'd2;
      timer_restart_d = 1'b1;
      timer_max_d     = phase_max(state_d);
`ifdef WATCHDOG_EN
      wdt_d           = 5'd0;
`endif
      if (state_d == S_WALK) begin
        pending_d = 1'b0;
        ped_ack_d = 1'b1;
      end
    end

    case (state_d)
      S_GREEN:  light_d = L_GREEN;
      S_YELLOW: light_d = L_YELLOW;
      S_FLASH:  light_d = (state_q == S_FLASH) ? (light_q ^ L_YELLOW) : L_YELLOW;
      default:  light_d = L_RED;
    endcase
    walk_d = (state_d == S_WALK);

`ifdef WATCHDOG_EN
    fault_d = (state_d == S_FLASH);
`endif
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q         <= S_RED;
      blank_q         <= 2'd2;
      pending_q       <= 1'b0;
      timer_max_q     <= 3'(T_RED);
      timer_restart_q <= 1'b1;
      light_q         <= L_RED;
      walk_q          <= 1'b0;
      ped_ack_q       <= 1'b0;
`ifdef WATCHDOG_EN
      wdt_q           <= 5'd0;
      fault_q         <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      blank_q         <= blank_d;
      pending_q       <= pending_d;
      timer_max_q     <= timer_max_d;
      timer_restart_q <= timer_restart_d;
      light_q         <= light_d;
      walk_q          <= walk_d;
      ped_ack_q       <= ped_ack_d;
`ifdef WATCHDOG_EN
      wdt_q           <= wdt_d;
      fault_q         <= fault_d;
`endif
    end
  end

  assign timer_max     = timer_max_q;
  assign timer_restart = timer_restart_q;
  assign light         = light_q;
  assign walk          = walk_q;
  assign ped_ack       = ped_ack_q;
`ifdef WATCHDOG_EN
  assign fault         = fault_q;
`else
  assign fault         = 1'b0;
`endif

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Phase-sequencing controller that drives the shared cycle-counter timer from its control side: it programs the timer limit, restarts the timer and consumes the timer's expiry flag. It sequences a single-approach traffic light with a pedestrian walk phase and latches pedestrian requests with a one-cycle acknowledge. It sits between the timer instance and the lamp/pedestrian I/O in the top-level FSM design.

## Interface
- T_GREEN, 5, green duration programmed into the timer (legal 1..7)
- T_YELLOW, 2, yellow duration (1..7)
- T_RED, 4, red duration without walk (1..7)
- T_WALK, 3, red-with-walk duration (1..7)
- WDT_LIMIT, 31, watchdog cycle limit (5-bit, used only with WATCHDOG_EN)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- timer_done  in  1  timer expiry flag (count >= limit)
- ped_req  in  1  pedestrian request, level, sampled every cycle
- timer_max  out  3  limit for the current phase, registered
- timer_restart  out  1  one-cycle pulse forcing timer count to 0
- light  out  3  one-hot lamps {red, yellow, green}
- walk  out  1  walk lamp
- ped_ack  out  1  one-cycle pulse: pending request accepted
- fault  out  1  watchdog fault (constant 0 without WATCHDOG_EN)

## Operation
- States: GREEN, YELLOW, RED, WALK, FLASH (FLASH only with WATCHDOG_EN).
- Transitions, taken on the accepting edge (below): GREEN->YELLOW; YELLOW->RED; RED->WALK if pending=1 else GREEN; WALK->GREEN.
- Outputs per state: GREEN light=001; YELLOW 010; RED 100; WALK 100 with walk=1; FLASH light=010 toggling every cycle, walk=0.
- Phase entry (every transition and reset): in the first cycle of the new state timer_restart=1, timer_max=that state's T_*, blank counter=2.
- blank decrements each cycle down to 0. timer_done is ignored while blank!=0, so a stale flag from the previous phase cannot end a phase.
- Accepting edge: first rising edge with blank==0 and timer_done==1.
- pending: set on any edge with ped_req=1, except the edge entering WALK. Cleared on the edge entering WALK. ped_ack=1 during the first WALK cycle only.
- A request held high through WALK re-arms pending from the second WALK cycle, so it is served next cycle round.
- timer_max is constant for the whole phase; it changes only on phase entry.

## Timing
- Reset values (cycle after any edge with reset=1): state RED, light=100, walk=0, ped_ack=0, timer_restart=1, timer_max=T_RED, pending=0, blank=2, fault=0.
- Reset mid-phase discards pending and any partial phase.
- Minimum phase length is 3 cycles: entry cycle plus 2 blanked cycles.
- If the timer raises done K cycles after the restart cycle (K>=2), the phase lasts K+1 cycles; the next state is visible on the following cycle.
- Outputs are registered; no combinational path from any input to any output.
- Priority on the same edge: reset > watchdog trip > timer acceptance > pending update.

## Configuration
- WATCHDOG_EN defined: a 5-bit counter clears on phase entry and increments each cycle in GREEN, YELLOW, RED and WALK.
  - When it reaches WDT_LIMIT without an accepting edge, next state is FLASH and fault=1.
  - FLASH holds until reset; timer_done and ped_req are ignored, timer_restart=0, ped_ack=0.
- WATCHDOG_EN undefined: no watchdog counter, FLASH unreachable, fault tied to 0.

## Test plan
- Reset, timer model asserting done 4 cycles after each restart, ped_req=0: light 100 for 5 cycles, then 001 for 5, then 010 for 5, then 100; timer_max 4,5,2,4; one timer_restart pulse per phase.
- Assert timer_done constantly from reset: every phase lasts exactly 3 cycles; sequence RED, GREEN, YELLOW, RED continues.
- Pulse ped_req for 1 cycle during GREEN: after RED, state WALK with light=100, walk=1, timer_max=3; ped_ack=1 in the first WALK cycle only; then GREEN.
- Hold ped_req high throughout: every RED is followed by WALK; exactly one ped_ack per WALK.
- Assert reset for 1 cycle mid-YELLOW: next cycle light=100, timer_restart=1, timer_max=4, pending=0 even if a request was latched.
- With WATCHDOG_EN defined and timer_done held 0: fault=1 and FLASH (light toggling 010/000) after WDT_LIMIT cycles in RED; stays there until reset. Without the macro: RED held indefinitely, fault=0.
